// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and widths for the memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_CPU_WAIT,
    ARB_CPU_DONE,
    ARB_VID_WAIT,
    ARB_VID_DONE
  } arb_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core, video fetcher and memory port bundle of the arbiter
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_out;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_in;
  logic              cpu_ce;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_address;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_out;
  logic              mem_we;
  logic [DATA_W-1:0] mem_in;

  modport slave (
    input  cpu_address, cpu_out, cpu_we, vid_req, vid_address, mem_in,
    output cpu_in, cpu_ce, vid_ack, vid_data, mem_address, mem_out, mem_we
  );

  modport master (
    output cpu_address, cpu_out, cpu_we, vid_req, vid_address, mem_in,
    input  cpu_in, cpu_ce, vid_ack, vid_data, mem_address, mem_out, mem_we
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between the core and video scanout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int VID_MAX = 4
) (
  input logic          clock,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] LAT_LAST  = 2'(MEM_LAT - 1);
  localparam logic [3:0] VID_MAX_C = 4'(VID_MAX);

  arb_state_t state, state_nxt;
  logic [1:0] wait_cnt;
  logic [3:0] vid_cnt;
  logic       vid_sel;
  logic       wait_last;
  logic       in_wait;

  assign vid_sel   = bus.vid_req && (vid_cnt < VID_MAX_C);
  assign wait_last = (wait_cnt == LAT_LAST);
  assign in_wait   = (state == ARB_CPU_WAIT) || (state == ARB_VID_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:     state_nxt = vid_sel ? ARB_VID_WAIT : ARB_CPU_WAIT;
      ARB_CPU_WAIT: if (wait_last) state_nxt = ARB_CPU_DONE;
      ARB_CPU_DONE: state_nxt = ARB_IDLE;
      ARB_VID_WAIT: if (wait_last) state_nxt = ARB_VID_DONE;
      ARB_VID_DONE: state_nxt = ARB_IDLE;
      default:      state_nxt = ARB_IDLE;
    endcase
  end

  // The address is already steered in IDLE so read data arrives in time to be
  // captured on the edge into DONE and presented together with cpu_ce/vid_ack.
  always_comb begin
    bus.mem_address = '0;
    bus.mem_out     = '0;
    bus.mem_we      = 1'b0;
    bus.cpu_ce      = 1'b0;
    bus.vid_ack     = 1'b0;
    case (state)
      ARB_IDLE: begin
        bus.mem_address = vid_sel ? bus.vid_address : bus.cpu_address;
        bus.mem_out     = vid_sel ? '0 : bus.cpu_out;
      end
      ARB_CPU_WAIT: begin
        bus.mem_address = bus.cpu_address;
        bus.mem_out     = bus.cpu_out;
        bus.mem_we      = bus.cpu_we && (wait_cnt == 2'd0);
      end
      ARB_CPU_DONE: begin
        bus.mem_address = bus.cpu_address;
        bus.mem_out     = bus.cpu_out;
        bus.cpu_ce      = 1'b1;
      end
      ARB_VID_WAIT: bus.mem_address = bus.vid_address;
      ARB_VID_DONE: begin
        bus.mem_address = bus.vid_address;
        bus.vid_ack     = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      bus.mem_address = '0;
      bus.mem_out     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= '0;
      vid_cnt      <= '0;
      bus.cpu_in   <= '0;
      bus.vid_data <= '0;
    end else begin
      wait_cnt <= (in_wait && !wait_last) ? wait_cnt + 2'd1 : 2'd0;
      if (state == ARB_CPU_WAIT && wait_last) bus.cpu_in   <= bus.mem_in;
      if (state == ARB_VID_WAIT && wait_last) bus.vid_data <= bus.mem_in;
      if (state == ARB_CPU_DONE) vid_cnt <= '0;
      else if (state == ARB_VID_DONE) vid_cnt <= sat_inc4(vid_cnt, VID_MAX_C);
    end
  end

endmodule
